// File: rtl/risc_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : risc_writeback_arbiter
// Description : Merges the ALU and load (LSU) result streams onto the single
//               register-file write port. Each source owns a one-entry
//               holding register behind a valid/ready handshake. The oldest
//               held entry is granted first; equal-age ties are broken by
//               TIE_LSU_FIRST. A pending-write mask exposes every destination
//               register whose result has not yet been committed.
// Ports       : clk, reset_n (async, active-low)
//               alu_valid/alu_ready/alu_rd/alu_data  - ALU result stream
//               lsu_valid/lsu_ready/lsu_rd/lsu_data  - load result stream
//               rd/rd_data/write_enable              - register-file write port
//               pending_mask                         - uncommitted rd bitmap
//               writes_retired                       - committed write count
// Revision    : 1.0 - initial release
// ============================================================================
module risc_writeback_arbiter #(
    parameter int          XLEN          = 32,
    parameter bit          TIE_LSU_FIRST = 1'b1,
    // Reset value of writes_retired; normally zero.
    parameter logic [31:0] RETIRED_RESET = 32'd0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data,
    output logic            write_enable,
    output logic [31:0]     pending_mask,
    output logic [31:0]     writes_retired
);

    localparam logic [4:0] c_X0 = 5'd0;

    // Holding entries
    logic            r_alu_vld;
    logic [4:0]      r_alu_rd;
    logic [XLEN-1:0] r_alu_data;
    logic            r_lsu_vld;
    logic [4:0]      r_lsu_rd;
    logic [XLEN-1:0] r_lsu_data;
    // Relative age; both clear means equal age. Only meaningful when both
    // entries are valid.
    logic            r_alu_older;
    logic            r_lsu_older;

    // Output stage
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rd_data;
    logic            r_we;
    logic [31:0]     r_retired;

    logic            w_grant_alu;
    logic            w_grant_lsu;
    logic            w_alu_acc;
    logic            w_lsu_acc;
    logic            w_alu_load;
    logic            w_lsu_load;
    logic            w_alu_keep;
    logic            w_lsu_keep;

    function automatic logic [31:0] f_decode(input logic [4:0] r);
        f_decode = 32'd1 << r;
    endfunction

    // ALU wins when it is alone, strictly older, or on a tie with ALU priority.
    assign w_grant_alu = r_alu_vld &&
                         (!r_lsu_vld || r_alu_older ||
                          (!r_lsu_older && !TIE_LSU_FIRST));
    assign w_grant_lsu = r_lsu_vld && !w_grant_alu;

    // Ready depends only on state; forced low while reset is asserted.
    assign alu_ready = reset_n && (!r_alu_vld || w_grant_alu);
    assign lsu_ready = reset_n && (!r_lsu_vld || w_grant_lsu);

    assign w_alu_acc  = alu_valid && alu_ready;
    assign w_lsu_acc  = lsu_valid && lsu_ready;
    // Writes to x0 complete the handshake but are dropped here.
    assign w_alu_load = w_alu_acc && (alu_rd != c_X0);
    assign w_lsu_load = w_lsu_acc && (lsu_rd != c_X0);
    assign w_alu_keep = r_alu_vld && !w_grant_alu;
    assign w_lsu_keep = r_lsu_vld && !w_grant_lsu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_vld   <= 1'b0;
            r_alu_rd    <= 5'd0;
            r_alu_data  <= '0;
            r_lsu_vld   <= 1'b0;
            r_lsu_rd    <= 5'd0;
            r_lsu_data  <= '0;
            r_alu_older <= 1'b0;
            r_lsu_older <= 1'b0;
        end else begin
            r_alu_vld <= w_alu_load || w_alu_keep;
            r_lsu_vld <= w_lsu_load || w_lsu_keep;
            if (w_alu_load) begin
                r_alu_rd   <= alu_rd;
                r_alu_data <= alu_data;
            end
            if (w_lsu_load) begin
                r_lsu_rd   <= lsu_rd;
                r_lsu_data <= lsu_data;
            end
            // At most one entry survives a cycle (one is always granted when
            // both are valid), so a surviving entry is older than anything
            // loaded beside it; two fresh loads are equal age.
            r_alu_older <= w_alu_keep && w_lsu_load;
            r_lsu_older <= w_lsu_keep && w_alu_load;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd      <= 5'd0;
            r_rd_data <= '0;
            r_we      <= 1'b0;
            r_retired <= RETIRED_RESET;
        end else begin
            r_we <= w_grant_alu || w_grant_lsu;
            if (w_grant_alu) begin
                r_rd      <= r_alu_rd;
                r_rd_data <= r_alu_data;
            end else if (w_grant_lsu) begin
                r_rd      <= r_lsu_rd;
                r_rd_data <= r_lsu_data;
            end
            if (r_we) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign rd             = r_rd;
    assign rd_data        = r_rd_data;
    assign write_enable   = r_we;
    assign writes_retired = r_retired;
    assign pending_mask   = (r_alu_vld ? f_decode(r_alu_rd) : 32'd0) |
                            (r_lsu_vld ? f_decode(r_lsu_rd) : 32'd0) |
                            (r_we      ? f_decode(r_rd)     : 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_risc_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_writeback_arbiter
// Description : Directed self-checking bench for risc_writeback_arbiter.
//               dut  : TIE_LSU_FIRST = 1, counter resets to 0.
//               dut2 : TIE_LSU_FIRST = 0, counter resets to 0xFFFFFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_writeback_arbiter;

    logic        clk;
    logic        reset_n;
    logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rd;
    logic [31:0] alu_data, lsu_data, rd_data, pending_mask, writes_retired;
    logic        write_enable;

    logic        b_alu_valid, b_lsu_valid, b_alu_ready, b_lsu_ready;
    logic [4:0]  b_alu_rd, b_lsu_rd, b_rd;
    logic [31:0] b_alu_data, b_lsu_data, b_rd_data, b_pending_mask, b_writes_retired;
    logic        b_write_enable;

    int n_total;
    int n_bad;

    risc_writeback_arbiter #(.XLEN(32), .TIE_LSU_FIRST(1'b1), .RETIRED_RESET(32'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rd(rd), .rd_data(rd_data), .write_enable(write_enable),
        .pending_mask(pending_mask), .writes_retired(writes_retired)
    );

    risc_writeback_arbiter #(.XLEN(32), .TIE_LSU_FIRST(1'b0), .RETIRED_RESET(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(b_alu_valid), .alu_ready(b_alu_ready), .alu_rd(b_alu_rd), .alu_data(b_alu_data),
        .lsu_valid(b_lsu_valid), .lsu_ready(b_lsu_ready), .lsu_rd(b_lsu_rd), .lsu_data(b_lsu_data),
        .rd(b_rd), .rd_data(b_rd_data), .write_enable(b_write_enable),
        .pending_mask(b_pending_mask), .writes_retired(b_writes_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        b_alu_valid = 1'b0; b_alu_rd = 5'd0; b_alu_data = 32'd0;
        b_lsu_valid = 1'b0; b_lsu_rd = 5'd0; b_lsu_data = 32'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        reset_n = 1'b0;
        #3;
        n_total++;
        if (write_enable !== 1'b0 || rd !== 5'd0 || rd_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_outputs: we=%b rd=%0d data=%h required 0/0/0", write_enable, rd, rd_data);
        end
        n_total++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: alu=%b lsu=%b required 0/0", alu_ready, lsu_ready);
        end
        n_total++;
        if (pending_mask !== 32'd0 || writes_retired !== 32'd0) begin
            n_bad++; $display("FAIL reset_state: pending=%h retired=%0d required 0/0", pending_mask, writes_retired);
        end
        tick();
        reset_n = 1'b1;
        #1;
        n_total++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: alu=%b lsu=%b required 1/1", alu_ready, lsu_ready);
        end
        tick();
    endtask

    // dut2: ALU wins ties; its counter starts at 0xFFFFFFFF and must wrap.
    task automatic test_tie_alu_first_wrap;
        n_total++;
        if (b_writes_retired !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL wrap_start: got=%h required=ffffffff", b_writes_retired);
        end
        b_alu_valid = 1'b1; b_alu_rd = 5'd3; b_alu_data = 32'h11;
        b_lsu_valid = 1'b1; b_lsu_rd = 5'd3; b_lsu_data = 32'h22;
        tick();
        b_alu_valid = 1'b0; b_lsu_valid = 1'b0;
        n_total++;
        if (b_alu_ready !== 1'b1 || b_lsu_ready !== 1'b0) begin
            n_bad++; $display("FAIL tie2_ready: alu=%b lsu=%b required 1/0", b_alu_ready, b_lsu_ready);
        end
        tick();
        n_total++;
        if (b_write_enable !== 1'b1 || b_rd !== 5'd3 || b_rd_data !== 32'h11) begin
            n_bad++; $display("FAIL tie2_first: we=%b rd=%0d data=%h required 1/3/11", b_write_enable, b_rd, b_rd_data);
        end
        tick();
        n_total++;
        if (b_write_enable !== 1'b1 || b_rd !== 5'd3 || b_rd_data !== 32'h22 || b_writes_retired !== 32'd0) begin
            n_bad++; $display("FAIL tie2_second_wrap: we=%b rd=%0d data=%h retired=%h required 1/3/22/0",
                              b_write_enable, b_rd, b_rd_data, b_writes_retired);
        end
        tick();
        n_total++;
        if (b_write_enable !== 1'b0 || b_writes_retired !== 32'd1 || b_pending_mask !== 32'd0) begin
            n_bad++; $display("FAIL tie2_drain: we=%b retired=%h pending=%h required 0/1/0",
                              b_write_enable, b_writes_retired, b_pending_mask);
        end
    endtask

    task automatic test_single_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        n_total++;
        if (alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_ready: got=%b required=1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_total++;
        if (pending_mask !== 32'h20 || write_enable !== 1'b0) begin
            n_bad++; $display("FAIL single_pending: pending=%h we=%b required 20/0", pending_mask, write_enable);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd5 || rd_data !== 32'hDEAD_BEEF || pending_mask !== 32'h20) begin
            n_bad++; $display("FAIL single_write: we=%b rd=%0d data=%h pending=%h required 1/5/deadbeef/20",
                              write_enable, rd, rd_data, pending_mask);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b0 || pending_mask !== 32'd0 || writes_retired !== 32'd1) begin
            n_bad++; $display("FAIL single_done: we=%b pending=%h retired=%0d required 0/0/1",
                              write_enable, pending_mask, writes_retired);
        end
        n_total++;
        if (rd !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL single_hold: rd=%0d data=%h required 5/deadbeef", rd, rd_data);
        end
    endtask

    task automatic test_tie;
        logic [31:0] last;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h22;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        n_total++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1 || pending_mask !== 32'h8) begin
            n_bad++; $display("FAIL tie_ready: alu=%b lsu=%b pending=%h required 0/1/8", alu_ready, lsu_ready, pending_mask);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd3 || rd_data !== 32'h22 || alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL tie_first: we=%b rd=%0d data=%h alu_ready=%b required 1/3/22/1",
                              write_enable, rd, rd_data, alu_ready);
        end
        tick();
        last = rd_data;
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd3 || last !== 32'h11) begin
            n_bad++; $display("FAIL tie_final_x3: we=%b rd=%0d data=%h required 1/3/11", write_enable, rd, last);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b0 || pending_mask !== 32'd0) begin
            n_bad++; $display("FAIL tie_drain: we=%b pending=%h required 0/0", write_enable, pending_mask);
        end
    endtask

    task automatic test_oldest_first;
        // Both loaded together; LSU wins the tie, leaving ALU x20 older.
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA20;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'hB21;
        tick();
        alu_valid = 1'b0;
        lsu_rd = 5'd7; lsu_data = 32'h707;
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd21 || pending_mask !== ((32'd1 << 20) | (32'd1 << 7) | (32'd1 << 21))) begin
            n_bad++; $display("FAIL old_w21: we=%b rd=%0d pending=%h required 1/21/00300080", write_enable, rd, pending_mask);
        end
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h808;
        lsu_rd = 5'd22; lsu_data = 32'h2222;
        tick();
        alu_valid = 1'b0;
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd20 || rd_data !== 32'hA20) begin
            n_bad++; $display("FAIL old_w20: we=%b rd=%0d data=%h required 1/20/a20", write_enable, rd, rd_data);
        end
        tick();
        lsu_valid = 1'b0;
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd7 || rd_data !== 32'h707) begin
            n_bad++; $display("FAIL old_w7: we=%b rd=%0d data=%h required 1/7/707", write_enable, rd, rd_data);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd8 || rd_data !== 32'h808) begin
            n_bad++; $display("FAIL old_w8: we=%b rd=%0d data=%h required 1/8/808", write_enable, rd, rd_data);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd22 || rd_data !== 32'h2222) begin
            n_bad++; $display("FAIL old_w22: we=%b rd=%0d data=%h required 1/22/2222", write_enable, rd, rd_data);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b0 || pending_mask !== 32'd0) begin
            n_bad++; $display("FAIL old_drain: we=%b pending=%h required 0/0", write_enable, pending_mask);
        end
    endtask

    task automatic test_x0_drop;
        logic [31:0] base;
        base = writes_retired;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        n_total++;
        if (alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL x0_ready: got=%b required=1", alu_ready);
        end
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        n_total++;
        if (pending_mask !== 32'h10 || alu_ready !== 1'b1) begin
            n_bad++; $display("FAIL x0_pending: pending=%h alu_ready=%b required 10/1", pending_mask, alu_ready);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b1 || rd !== 5'd4 || rd_data !== 32'h44) begin
            n_bad++; $display("FAIL x0_lsu_write: we=%b rd=%0d data=%h required 1/4/44", write_enable, rd, rd_data);
        end
        tick();
        n_total++;
        if (write_enable !== 1'b0 || pending_mask !== 32'd0 || writes_retired !== base + 32'd1) begin
            n_bad++; $display("FAIL x0_no_write: we=%b pending=%h retired=%0d required 0/0/%0d",
                              write_enable, pending_mask, writes_retired, base + 32'd1);
        end
    endtask

    task automatic test_reset_mid;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        n_total++;
        if (write_enable !== 1'b0 || alu_ready !== 1'b0 || lsu_ready !== 1'b0 ||
            pending_mask !== 32'd0 || writes_retired !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid: we=%b ar=%b lr=%b pending=%h retired=%0d required 0/0/0/0/0",
                              write_enable, alu_ready, lsu_ready, pending_mask, writes_retired);
        end
        idle_inputs();
        tick();
        reset_n = 1'b1;
        #1;
        n_total++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_ready: alu=%b lsu=%b required 1/1", alu_ready, lsu_ready);
        end
        tick(); tick();
        n_total++;
        if (write_enable !== 1'b0 || writes_retired !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid_discard: we=%b retired=%0d required 0/0", write_enable, writes_retired);
        end
    endtask

    task automatic test_back_to_back;
        logic [36:0] qa[$];
        logic [36:0] ql[$];
        int          ia, il, cyc;
        logic [31:0] base;
        base = writes_retired;
        ia = 0; il = 0; cyc = 0;
        alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd16; lsu_data = 32'h5000_0000;
        while (cyc < 400) begin
            if (alu_valid && alu_ready) begin qa.push_back({alu_rd, alu_data}); ia++; end
            if (lsu_valid && lsu_ready) begin ql.push_back({lsu_rd, lsu_data}); il++; end
            tick();
            cyc++;
            if (write_enable) begin
                n_total++;
                if (qa.size() > 0 && {rd, rd_data} === qa[0]) void'(qa.pop_front());
                else if (ql.size() > 0 && {rd, rd_data} === ql[0]) void'(ql.pop_front());
                else begin
                    n_bad++; $display("FAIL b2b_write: rd=%0d data=%h required head of a source queue", rd, rd_data);
                end
            end
            alu_valid = (ia < 100);
            alu_rd    = 5'(1 + ia % 15);
            alu_data  = 32'hA000_0000 + 32'(ia);
            lsu_valid = (il < 100);
            lsu_rd    = 5'(16 + il % 16);
            lsu_data  = 32'h5000_0000 + 32'(il);
            if (ia == 100 && il == 100 && qa.size() == 0 && ql.size() == 0 && !write_enable) break;
        end
        n_total++;
        if (ia != 100 || il != 100 || qa.size() != 0 || ql.size() != 0) begin
            n_bad++; $display("FAIL b2b_complete: alu=%0d lsu=%0d left=%0d required 100/100/0", ia, il, qa.size() + ql.size());
        end
        n_total++;
        if (cyc > 205) begin
            n_bad++; $display("FAIL b2b_throughput: cycles=%0d required<=205", cyc);
        end
        n_total++;
        if (writes_retired - base !== 32'd200 || pending_mask !== 32'd0) begin
            n_bad++; $display("FAIL b2b_retired: delta=%0d pending=%h required 200/0", writes_retired - base, pending_mask);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle_inputs();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_tie_alu_first_wrap();
        test_single_alu();
        test_tie();
        test_oldest_first();
        test_x0_drop();
        test_reset_mid();
        do_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
